// File: rtl/rr_fifo_pkg.sv
// Shared widths and helpers for the round-robin FIFO arbiter slice.
// entry_t itself depends on the payload type, so each instantiating scope declares it.
package rr_fifo_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned DEPTH_DEFAULT   = 8;
  localparam int unsigned SRC_W           = $clog2(NUM_REQ_DEFAULT);
  localparam int unsigned OCC_W           = $clog2(DEPTH_DEFAULT) + 1;

  function automatic int unsigned src_width(input int unsigned num_req);
    return $clog2(num_req);
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/circular_buffer.sv
// Circular buffer with a registered read port and an overwrite-oldest path on full writes.
// Synchronous active-high reset.
module circular_buffer #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_en,
  input  T                       write_data,
  input  logic                   read_en,
  output T                       read_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  T                 read_data_q;
  logic             do_read, overwrite;

  assign full      = (count_q == (AddrW + 1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_read   = read_en & ~empty;
  assign overwrite = write_en & full & ~do_read;
  assign read_data = read_data_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr_q] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= T'('0);
    end else begin
      if (do_read) begin
        read_data_q <= mem[rd_ptr_q];
      end
      if (write_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      // Overwrite drops the oldest entry, so the read pointer moves with the write.
      if (do_read || overwrite) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (write_en && !do_read && !full) begin
        count_q <= count_q + 1'b1;
      end else if (do_read && !write_en) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered priority pointer.
// The pointer moves past the winner only when the caller reports an accepted transfer.
module rr_arbiter
  import rr_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned SrcW = src_width(NUM_REQ);

  logic [SrcW-1:0] rr_ptr_q, rr_ptr_d;
  logic            found;

  always_comb begin
    int unsigned     idx;
    logic [SrcW-1:0] cand;
    idx       = 0;
    cand      = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand = SrcW'(idx);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant            = '0;
    grant[grant_idx] = found;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (grant_idx == SrcW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin write arbiter feeding one shared circular buffer, with a valid/ready output
// stage that hides the buffer's registered read latency from the consumer.
module rr_fifo_arbiter
  import rr_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 8,
  parameter type         T       = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  T                           req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output T                           out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned SrcW = src_width(NUM_REQ);
  localparam int unsigned OccW = occ_width(DEPTH);

  typedef struct packed {
    logic [SrcW-1:0] src;
    T                data;
  } entry_t;

  logic [NUM_REQ-1:0] grant;
  logic [SrcW-1:0]    grant_idx;
  logic               full, empty, pop, space, push;
  entry_t             wr_entry, rd_entry;
  logic [OccW-1:0]    buf_count, occ_q, occ_d;
  logic               out_valid_q, out_valid_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (push),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  circular_buffer #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (~reset),
    .write_en   (push),
    .write_data (wr_entry),
    .read_en    (pop),
    .read_data  (rd_entry),
    .full       (full),
    .empty      (empty),
    .count      (buf_count)
  );

  assign pop   = ~empty & (~out_valid_q | out_ready);
  assign space = ~full | pop;
  // Gating with reset keeps a handshake in the reset cycle from counting as a transfer.
  assign req_ready = (reset && space) ? grant : '0;
  assign push      = |(req_valid & req_ready);
  assign wr_entry  = '{src: grant_idx, data: req_data[grant_idx]};

  assign out_valid = out_valid_q;
  assign out_data  = rd_entry.data;
  assign out_src   = rd_entry.src;
  assign occupancy = occ_q;

  always_comb begin
    out_valid_d = out_valid_q;
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  a_full_match:  assert property (@(posedge clk) disable iff (!reset)
                                  full == (occ_q == OccW'(DEPTH)));
  a_empty_match: assert property (@(posedge clk) disable iff (!reset) empty == (occ_q == '0));
  a_count_match: assert property (@(posedge clk) disable iff (!reset) occ_q == buf_count);
  a_no_overwr:   assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed and randomized bench for rr_fifo_arbiter against a queue-based reference model.
module tb_rr_fifo_arbiter;

  localparam int NR = 4;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [31:0]   req_data [NR];
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [1:0]    out_src;
  logic          out_ready;
  logic [3:0]    occupancy;

  rr_fifo_arbiter #(
    .NUM_REQ (NR),
    .DEPTH   (DP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Model: buffered entries {src, data}, the output slot, and the priority pointer.
  logic [33:0] mq [$];
  logic [33:0] slot;
  bit          slot_v;
  int          rr;
  int          last_acc;
  int          n_checks;
  int          n_errors;
  logic [3:0]  bp_pat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against model, cross the edge, advance the model.
  task automatic step();
    int            g;
    bit            pop, space;
    logic [NR-1:0] exp_ready;
    #1;
    pop   = (mq.size() != 0) && (!slot_v || out_ready);
    space = (mq.size() < DP) || pop;
    g     = -1;
    for (int k = 0; k < NR; k++) begin
      if (g < 0 && req_valid[(rr + k) % NR]) g = (rr + k) % NR;
    end
    exp_ready = '0;
    if (reset && space && g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("out_valid", out_valid, slot_v);
    check("out_data", out_data, slot[31:0]);
    check("out_src", out_src, slot[33:32]);
    check("occupancy", occupancy, mq.size());
    @(posedge clk);
    last_acc = -1;
    if (!reset) begin
      mq.delete();
      slot   = '0;
      slot_v = 1'b0;
      rr     = 0;
    end else begin
      if (pop) begin
        slot   = mq.pop_front();
        slot_v = 1'b1;
      end else if (out_ready) begin
        slot_v = 1'b0;
      end
      if (exp_ready != '0) begin
        mq.push_back({2'(g), req_data[g]});
        rr       = (g + 1) % NR;
        last_acc = g;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rr       = 0;
    slot     = '0;
    slot_v   = 1'b0;
    last_acc = -1;
    bp_pat   = 4'b1001;
    reset     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NR; i++) req_data[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values, with requests present while reset is held.
    req_valid = '1;
    step();
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_occupancy", occupancy, 64'd0);
    #1 check("rst_req_ready", req_ready, 64'd0);
    step();

    // Single push: minimum two-cycle latency.
    reset     = 1'b1;
    req_valid = 4'b0100;
    req_data[2] = 32'hA5;
    out_ready = 1'b1;
    #1 check("single_ready", req_ready, 64'b0100);
    step();
    req_valid = '0;
    check("single_c1_valid", out_valid, 64'd0);
    step();
    check("single_c2_valid", out_valid, 64'd1);
    check("single_c2_data", out_data, 64'hA5);
    check("single_c2_src", out_src, 64'd2);
    repeat (2) step();

    // Round-robin with all producers valid.
    do_reset();
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i] = 32'h100 + i;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_grant", req_ready, 64'b0001 << (k % 4));
      step();
      if (last_acc >= 0) req_data[last_acc] = $urandom;
    end
    req_valid = '0;
    repeat (4) step();

    // Fill: one word in the output stage, eight in the buffer.
    do_reset();
    out_ready   = 1'b0;
    req_valid   = 4'b0010;
    req_data[1] = 32'hF000;
    for (int k = 0; k < 9; k++) begin
      step();
      if (last_acc == 1) req_data[1] = 32'hF001 + k;
    end
    req_valid = '0;
    check("full_occupancy", occupancy, 64'd8);
    check("full_head", out_data, 64'hF000);
    req_valid   = 4'b1101;
    req_data[0] = 32'hC0;
    req_data[2] = 32'hC2;
    req_data[3] = 32'hC3;
    #1 check("full_blocked", req_ready, 64'd0);
    repeat (3) step();
    check("full_hold_occ", occupancy, 64'd8);

    // Full with draining: pointer held at 2 while blocked, push per cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("full_rr_grant", req_ready, 64'b0001 << ((k + 2) % 4));
      step();
      check("full_traffic_occ", occupancy, 64'd8);
    end
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      req_data[1] = 32'hD000 + k;
      #1 check("full_single_ready", req_ready, 64'b0010);
      step();
      check("full_single_occ", occupancy, 64'd8);
    end
    req_valid = '0;
    repeat (12) step();
    check("drain_occ", occupancy, 64'd0);
    check("drain_valid", out_valid, 64'd0);

    // Backpressure on a valid output stage.
    out_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      req_data[0] = 32'hB000 + k;
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      out_ready = bp_pat[k % 4];
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();

    // Reset mid-stream with five entries buffered.
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      req_data[1] = 32'hE000 + k;
      step();
    end
    check("mid_occ_before", occupancy, 64'd5);
    req_valid = '1;
    do_reset();
    check("mid_out_valid", out_valid, 64'd0);
    check("mid_occ_after", occupancy, 64'd0);
    req_valid = 4'b0110;
    #1 check("mid_grant", req_ready, 64'b0010);
    step();
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) < ((c % 200) < 100 ? 1 : 3));
      reset     = ($urandom_range(0, 79) != 0);
      step();
      if (!reset) begin
        req_valid = '0;
      end else if (last_acc >= 0) begin
        req_valid[last_acc] = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_data[i]  = $urandom;
        end
      end
    end
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (12) step();
    check("final_occ", occupancy, 64'd0);
    check("final_valid", out_valid, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
